// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: four-way byte arbiter feeding a single UART transmitter.
// Round-robin selection, frame locking with an idle timeout, and one byte
// paced every 10*CLOCKS_PER_BAUD clocks.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | arbitrating; req_ready_o may strobe for the selected requester
// ST_SEND  | write_o pulse to the transmitter with the captured byte
// ST_WAIT  | pacing the rest of the byte frame before the next accept
module uart_tx_arbiter #(
  parameter int CLOCKS_PER_BAUD = 104,
  parameter int LOCK_TIMEOUT    = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  req_valid_i,
  input  logic [31:0] req_data_i,
  input  logic [3:0]  req_last_i,
  output logic [3:0]  req_ready_o,
  output logic        write_o,
  output logic [7:0]  data_o,
  output logic [1:0]  grant_o,
  output logic        busy_o
);

  localparam int FRAME = 10 * CLOCKS_PER_BAUD;
  localparam int WW    = $clog2(FRAME + 1);
  localparam int TW    = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  // Counter counts down to 0 inclusive, giving FRAME-2 WAIT cycles.
  localparam logic [WW-1:0] WAIT_LOAD = WW'(FRAME - 3);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT} state_t;

  state_t          state;
  logic            lock_vld;
  logic [1:0]      lock_own;
  logic [WW-1:0]   wait_cnt;
  logic [TW-1:0]   to_cnt;
  logic            sel_found;
  logic [1:0]      sel_idx;
  logic            accept;

  // Pick the eligible requester: the lock owner only, or round-robin from grant_o+1.
  always_comb begin
    logic [1:0] idx;
    sel_found = 1'b0;
    sel_idx   = 2'd0;
    idx       = 2'd0;
    if (lock_vld) begin
      if (req_valid_i[lock_own]) begin
        sel_found = 1'b1;
        sel_idx   = lock_own;
      end
    end else begin
      // Iterate from the farthest offset down so the nearest offset wins.
      for (int k = 4; k >= 1; k--) begin
        idx = grant_o + 2'(k);
        if (req_valid_i[idx]) begin
          sel_found = 1'b1;
          sel_idx   = idx;
        end
      end
    end
  end

  // Accept strobe is combinational and suppressed while reset is held.
  always_comb begin
    req_ready_o = 4'b0000;
    if (state == ST_IDLE && sel_found && !reset)
      req_ready_o = 4'b0001 << sel_idx;
  end

  assign accept = |req_ready_o;

  // Main sequencer: arbitration, byte capture, pacing and lock timeout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      write_o  <= 1'b0;
      data_o   <= 8'h00;
      grant_o  <= 2'd3;
      busy_o   <= 1'b0;
      lock_vld <= 1'b0;
      lock_own <= 2'd0;
      wait_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      write_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            data_o   <= req_data_i[{sel_idx, 3'b000} +: 8];
            grant_o  <= sel_idx;
            lock_vld <= ~req_last_i[sel_idx];
            lock_own <= sel_idx;
            to_cnt   <= '0;
            write_o  <= 1'b1;
            busy_o   <= 1'b1;
            state    <= ST_SEND;
          end else if (lock_vld && LOCK_TIMEOUT != 0) begin
            // No accept while locked means the owner is not presenting a byte.
            if (to_cnt == TW'(LOCK_TIMEOUT)) begin
              lock_vld <= 1'b0;
              to_cnt   <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end else begin
            to_cnt <= '0;
          end
        end
        ST_SEND: begin
          to_cnt   <= '0;
          wait_cnt <= WAIT_LOAD;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          to_cnt <= '0;
          if (wait_cnt == '0) begin
            busy_o <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a time-based behavioural model.
module tb_uart_tx_arbiter;

  localparam int CPB   = 4;
  localparam int LT    = 16;
  localparam int FRAME = 10 * CPB;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_last_i;
  logic [3:0]  req_ready_o;
  logic        write_o;
  logic [7:0]  data_o;
  logic [1:0]  grant_o;
  logic        busy_o;

  uart_tx_arbiter #(.CLOCKS_PER_BAUD(CPB), .LOCK_TIMEOUT(LT)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .write_o     (write_o),
    .data_o      (data_o),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Requester byte sources: {last, data}
  logic [8:0] src_q [4][$];

  // Reference model: time of last accept, grant, lock and idle counter.
  int         m_acc;
  int         m_grant;
  bit         m_lock_v;
  int         m_lock_own;
  int         m_to;
  logic [7:0] m_data;

  // Observed DUT accepts.
  int acc_id_log[$];
  int acc_cyc_log[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_acc      = -1;
    m_grant    = 3;
    m_lock_v   = 1'b0;
    m_lock_own = 0;
    m_to       = 0;
    m_data     = 8'h00;
  endtask

  task automatic step();
    int  win;
    bit  m_busy;
    bit  exp_write;
    logic [3:0] exp_ready;
    @(negedge clock);
    for (int n = 0; n < 4; n++) begin
      if (src_q[n].size() > 0) begin
        req_valid_i[n]          = 1'b1;
        req_data_i[8*n +: 8]    = src_q[n][0][7:0];
        req_last_i[n]           = src_q[n][0][8];
      end else begin
        req_valid_i[n]          = 1'b0;
        req_data_i[8*n +: 8]    = 8'($urandom);
        req_last_i[n]           = 1'($urandom);
      end
    end
    #1;
    m_busy    = (m_acc >= 0) && (cyc > m_acc) && (cyc < m_acc + FRAME);
    exp_write = (m_acc >= 0) && (cyc == m_acc + 1);
    win = -1;
    if (!reset && !m_busy) begin
      if (m_lock_v) begin
        if (req_valid_i[m_lock_own]) win = m_lock_own;
      end else begin
        for (int k = 1; k <= 4; k++) begin
          int idx;
          idx = (m_grant + k) % 4;
          if (win < 0 && req_valid_i[idx]) win = idx;
        end
      end
    end
    exp_ready = (win >= 0) ? (4'b0001 << win) : 4'b0000;
    check_val("ready", 32'(req_ready_o), 32'(exp_ready));
    check_val("write", 32'(write_o), 32'(exp_write));
    check_val("data",  32'(data_o), 32'(m_data));
    check_val("grant", 32'(grant_o), 32'(m_grant));
    check_val("busy",  32'(busy_o), 32'(m_busy));
    for (int n = 0; n < 4; n++) begin
      if (req_ready_o[n] && req_valid_i[n]) begin
        acc_id_log.push_back(n);
        acc_cyc_log.push_back(cyc);
      end
    end
    @(posedge clock);
    if (!reset) begin
      if (win >= 0) begin
        m_acc      = cyc;
        m_data     = src_q[win][0][7:0];
        m_grant    = win;
        m_lock_v   = ~src_q[win][0][8];
        m_lock_own = win;
        m_to       = 0;
        void'(src_q[win].pop_front());
      end else if (!m_busy && m_lock_v) begin
        if (m_to == LT) begin
          m_lock_v = 1'b0;
          m_to     = 0;
        end else begin
          m_to++;
        end
      end else begin
        m_to = 0;
      end
    end
    cyc++;
  endtask

  // Raise reset mid-cycle so its effect is visible before any clock edge.
  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_val("rst_ready", 32'(req_ready_o), 32'h0);
    check_val("rst_write", 32'(write_o), 32'h0);
    check_val("rst_data",  32'(data_o), 32'h0);
    check_val("rst_grant", 32'(grant_o), 32'h3);
    check_val("rst_busy",  32'(busy_o), 32'h0);
    repeat (2) step();
    #1 reset = 1'b0;
  endtask

  task automatic clear_logs();
    acc_id_log.delete();
    acc_cyc_log.delete();
  endtask

  initial begin
    reset       = 1'b1;
    req_valid_i = 4'b0;
    req_data_i  = 32'b0;
    req_last_i  = 4'b0;
    model_reset();
    do_reset();

    // Single byte from requester 0.
    clear_logs();
    src_q[0].push_back({1'b1, 8'h41});
    repeat (45) step();
    check_val("single_cnt", 32'(acc_id_log.size()), 32'd1);

    // All four valid at once: expect order 0,1,2,3 spaced by FRAME clocks.
    do_reset();
    clear_logs();
    for (int n = 0; n < 4; n++) src_q[n].push_back({1'b1, 8'(8'h10 + n)});
    repeat (170) step();
    check_val("rr_cnt", 32'(acc_id_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < acc_id_log.size()) begin
        check_val("rr_order", 32'(acc_id_log[i]), 32'(i));
        if (i > 0) check_val("rr_spacing", 32'(acc_cyc_log[i] - acc_cyc_log[i-1]), 32'(FRAME));
      end
    end

    // Frame lock: requester 2 holds the line for three bytes against requester 1.
    clear_logs();
    src_q[2].push_back({1'b0, 8'hA0});
    src_q[2].push_back({1'b0, 8'hA1});
    src_q[2].push_back({1'b1, 8'hA2});
    step();
    src_q[1].push_back({1'b1, 8'hB0});
    src_q[1].push_back({1'b1, 8'hB1});
    repeat (220) step();
    check_val("lock_cnt", 32'(acc_id_log.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < acc_id_log.size())
        check_val("lock_order", 32'(acc_id_log[i]), (i < 3) ? 32'd2 : 32'd1);

    // Lock timeout: requester 3 leaves a frame open, requester 0 waits it out.
    do_reset();
    clear_logs();
    src_q[3].push_back({1'b0, 8'hC3});
    step();
    src_q[0].push_back({1'b1, 8'h50});
    repeat (80) step();
    check_val("to_cnt", 32'(acc_id_log.size()), 32'd2);
    if (acc_id_log.size() == 2) begin
      check_val("to_first", 32'(acc_id_log[0]), 32'd3);
      check_val("to_second", 32'(acc_id_log[1]), 32'd0);
      // FRAME clocks until IDLE, then LT+1 idle clocks before release.
      check_val("to_delay", 32'(acc_cyc_log[1] - acc_cyc_log[0]), 32'(FRAME + LT + 1));
    end

    // Reset during WAIT aborts the byte; no further write pulse.
    clear_logs();
    src_q[1].push_back({1'b1, 8'h77});
    repeat (10) step();
    do_reset();
    repeat (45) step();
    check_val("abort_cnt", 32'(acc_id_log.size()), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        int r;
        r = $urandom_range(0, 3);
        if (src_q[r].size() < 3) src_q[r].push_back({1'($urandom), 8'($urandom)});
      end
      if ($urandom_range(0, 999) == 0) do_reset();
      step();
    end
    for (int n = 0; n < 4; n++) src_q[n].delete();
    repeat (FRAME + 2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
